jtag_fifo_bridge: RTL and testbench

Parametrised virtual-JTAG data bridge for the collision-detection input path. It runs entirely in the JTAG `tck` domain, driven by the virtual JTAG instance's state strobes. PUSH words are shifted in and queued in a receive FIFO, then drained by logic through a valid/ack handshake. Words the logic supplies are queued in a transmit FIFO and shifted out on POP. A STAT command returns FIFO levels and sticky error flags to the host.

---
 rtl/jtag_bridge_pkg.sv | 32 +++
 rtl/jtag_sfifo.sv | 76 +++++++
 rtl/jtag_fifo_bridge.sv | 182 ++++++++++++++++++
 tb/tb_jtag_fifo_bridge.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_bridge_pkg.sv
// rtl/jtag_bridge_pkg.sv - shared codes, status layout and helpers for the virtual-JTAG FIFO bridge
package jtag_bridge_pkg;

    localparam int unsigned IR_PUSH_DEF = 1;
    localparam int unsigned IR_POP_DEF  = 2;
    localparam int unsigned IR_STAT_DEF = 3;

    localparam int STAT_RXCNT_LSB = 0;
    localparam int STAT_TXCNT_LSB = 8;
    localparam int STAT_OVF_BIT   = 16;
    localparam int STAT_UNF_BIT   = 17;
    localparam int STAT_CNT_W     = 8;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_PUSH,
        DR_POP,
        DR_STAT
    } dr_sel_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/jtag_sfifo.sv
// rtl/jtag_sfifo.sv - single-clock circular FIFO; head is shown on rd_data, forced to 0 when empty
module jtag_sfifo
    import jtag_bridge_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_wr, do_rd;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    // Fullness is judged on the registered count, so a write to a full
    // FIFO is refused even when a read frees a slot on the same edge.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/jtag_fifo_bridge.sv
// rtl/jtag_fifo_bridge.sv - virtual-JTAG PUSH/POP/STAT data bridge with receive and transmit FIFOs, all on tck
module jtag_fifo_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          IR_W    = 3,
    parameter int          DEPTH   = 4,
    parameter int unsigned IR_PUSH = IR_PUSH_DEF,
    parameter int unsigned IR_POP  = IR_POP_DEF,
    parameter int unsigned IR_STAT = IR_STAT_DEF
) (
    input  logic              tck,
    input  logic              reset,
    input  logic [IR_W-1:0]   ir_in,
    input  logic              tdi,
    input  logic              cdr,
    input  logic              sdr,
    input  logic              udr,
    output logic              tdo,
    output logic [DATA_W-1:0] out_data,
    output logic              out_rdy,
    input  logic              out_ack,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_rdy,
    output logic              push_ovf,
    output logic              pop_unf
);

    localparam int CW = clog2(DEPTH) + 1;

    dr_sel_e           sel;
    logic              is_push, is_pop, is_stat;

    logic [DATA_W-1:0] shift_in_q, shift_in_d;
    logic [DATA_W-1:0] shift_out_q, shift_out_d;
    logic [DATA_W-1:0] shift_st_q, shift_st_d;
    logic              push_ovf_q, push_ovf_d;
    logic              pop_unf_q, pop_unf_d;

    logic              rx_wr, rx_full, rx_empty;
    logic [CW-1:0]     rx_count;
    logic [DATA_W-1:0] rx_head;

    logic              tx_wr, tx_rd, tx_full, tx_empty;
    logic [CW-1:0]     tx_count;
    logic [DATA_W-1:0] tx_head;

    logic              ovf_set, unf_set, flag_clr;
    logic [DATA_W-1:0] stat_word;

    always_comb begin
        sel = DR_BYPASS;
        if (ir_in == IR_W'(IR_PUSH)) begin
            sel = DR_PUSH;
        end else if (ir_in == IR_W'(IR_POP)) begin
            sel = DR_POP;
        end else if (ir_in == IR_W'(IR_STAT)) begin
            sel = DR_STAT;
        end
    end

    assign is_push = (sel == DR_PUSH);
    assign is_pop  = (sel == DR_POP);
    assign is_stat = (sel == DR_STAT);

    assign rx_wr   = udr && is_push;
    assign ovf_set = rx_wr && rx_full;

    assign in_rdy  = !tx_full && !reset;
    assign tx_wr   = in_valid && in_rdy;
    assign tx_rd   = cdr && is_pop && !tx_empty;
    assign unf_set = cdr && is_pop && tx_empty;

    assign flag_clr = udr && is_stat;

    jtag_sfifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rx_fifo (
        .clk     (tck),
        .reset   (reset),
        .wr_en   (rx_wr),
        .wr_data (shift_in_q),
        .rd_en   (out_ack),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    jtag_sfifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tx_fifo (
        .clk     (tck),
        .reset   (reset),
        .wr_en   (tx_wr),
        .wr_data (in_data),
        .rd_en   (tx_rd),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    assign out_rdy  = !rx_empty;
    assign out_data = rx_head;
    assign push_ovf = push_ovf_q;
    assign pop_unf  = pop_unf_q;

    // Status is built from registered counts/flags, i.e. the state before this edge.
    always_comb begin
        stat_word = '0;
        stat_word[STAT_RXCNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(rx_count);
        stat_word[STAT_TXCNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(tx_count);
        stat_word[STAT_OVF_BIT]                 = push_ovf_q;
        stat_word[STAT_UNF_BIT]                 = pop_unf_q;
    end

    always_comb begin
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        shift_st_d  = shift_st_q;
        push_ovf_d  = push_ovf_q;
        pop_unf_d   = pop_unf_q;

        if (sdr && is_push) begin
            shift_in_d = {tdi, shift_in_q[DATA_W-1:1]};
        end

        if (cdr && is_pop) begin
            shift_out_d = tx_empty ? '0 : tx_head;
        end else if (sdr && is_pop) begin
            shift_out_d = {tdi, shift_out_q[DATA_W-1:1]};
        end

        if (cdr && is_stat) begin
            shift_st_d = stat_word;
        end else if (sdr && is_stat) begin
            shift_st_d = {tdi, shift_st_q[DATA_W-1:1]};
        end

        // A new error on the clearing edge must not be lost.
        if (flag_clr) begin
            push_ovf_d = 1'b0;
            pop_unf_d  = 1'b0;
        end
        if (ovf_set) begin
            push_ovf_d = 1'b1;
        end
        if (unf_set) begin
            pop_unf_d = 1'b1;
        end
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            shift_in_q  <= '0;
            shift_out_q <= '0;
            shift_st_q  <= '0;
            push_ovf_q  <= 1'b0;
            pop_unf_q   <= 1'b0;
        end else begin
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            shift_st_q  <= shift_st_d;
            push_ovf_q  <= push_ovf_d;
            pop_unf_q   <= pop_unf_d;
        end
    end

    always_comb begin
        case (sel)
            DR_PUSH: tdo = shift_in_q[0];
            DR_POP:  tdo = shift_out_q[0];
            DR_STAT: tdo = shift_st_q[0];
            default: tdo = tdi;
        endcase
    end

endmodule

// File: tb/tb_jtag_fifo_bridge.sv
// tb/tb_jtag_fifo_bridge.sv - directed self-checking bench for jtag_fifo_bridge (default parameters)
module tb_jtag_fifo_bridge;

    localparam logic [2:0] IRP = 3'd1;
    localparam logic [2:0] IRO = 3'd2;
    localparam logic [2:0] IRS = 3'd3;

    logic        tck = 1'b0;
    logic        reset;
    logic [2:0]  ir_in;
    logic        tdi, cdr, sdr, udr;
    logic        tdo;
    logic [31:0] out_data;
    logic        out_rdy, out_ack;
    logic [31:0] in_data;
    logic        in_valid, in_rdy;
    logic        push_ovf, pop_unf;

    int total = 0;
    int bad   = 0;

    logic [31:0] got;
    logic [31:0] words [5];

    jtag_fifo_bridge dut (
        .tck      (tck),
        .reset    (reset),
        .ir_in    (ir_in),
        .tdi      (tdi),
        .cdr      (cdr),
        .sdr      (sdr),
        .udr      (udr),
        .tdo      (tdo),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .out_ack  (out_ack),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_rdy   (in_rdy),
        .push_ovf (push_ovf),
        .pop_unf  (pop_unf)
    );

    always #5 tck = ~tck;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        sdr  = 1'b1;
        for (int i = 0; i < n; i++) begin
            tdi = din[i];
            #1;
            dout[i] = tdo;
            tick();
        end
        sdr = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic strobe_udr(input logic [2:0] ir, input logic ack);
        ir_in   = ir;
        udr     = 1'b1;
        out_ack = ack;
        tick();
        udr     = 1'b0;
        out_ack = 1'b0;
    endtask

    task automatic strobe_cdr(input logic [2:0] ir);
        ir_in = ir;
        cdr   = 1'b1;
        tick();
        cdr   = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        logic [31:0] dummy;
        ir_in = IRP;
        shift_bits(32, w, dummy);
        strobe_udr(IRP, 1'b0);
    endtask

    task automatic ack_once();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    task automatic read_stat(output logic [31:0] s);
        strobe_cdr(IRS);
        shift_bits(32, 32'h0, s);
    endtask

    task automatic tx_write(input logic [31:0] w);
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ir_in = IRP; tdi = 1'b1; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
        out_ack = 1'b0; in_data = '0; in_valid = 1'b0;
        tick(); tick();

        check_eq("rst_in_rdy", {31'b0, in_rdy}, 32'd0);
        check_eq("rst_out_rdy", {31'b0, out_rdy}, 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_flags", {30'b0, pop_unf, push_ovf}, 32'd0);
        check_eq("rst_tdo_push", {31'b0, tdo}, 32'd0);
        reset = 1'b0; tdi = 1'b0;
        tick();
        check_eq("in_rdy_after_rst", {31'b0, in_rdy}, 32'd1);

        push_word(32'hDEADBEEF);
        check_eq("push_rdy", {31'b0, out_rdy}, 32'd1);
        check_eq("push_data", out_data, 32'hDEADBEEF);
        ack_once();
        check_eq("ack_rdy", {31'b0, out_rdy}, 32'd0);
        check_eq("ack_data", out_data, 32'd0);

        words[0] = 32'hA0A0_0001; words[1] = 32'h1234_5670; words[2] = 32'hFFFF_0000;
        words[3] = 32'h0F0F_F0F0; words[4] = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) push_word(words[i]);
        check_eq("ovf_set", {31'b0, push_ovf}, 32'd1);
        read_stat(got);
        check_eq("stat_full_ovf", got, 32'h0001_0004);
        strobe_udr(IRS, 1'b0);
        check_eq("ovf_clear", {31'b0, push_ovf}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain%0d", i), out_data, words[i]);
            ack_once();
        end
        check_eq("drain_empty", {31'b0, out_rdy}, 32'd0);

        tx_write(32'h12345678);
        check_eq("tx_in_rdy", {31'b0, in_rdy}, 32'd1);
        strobe_cdr(IRO);
        ir_in = IRO;
        shift_bits(32, 32'h0, got);
        check_eq("pop_word", got, 32'h12345678);
        check_eq("pop_in_rdy", {31'b0, in_rdy}, 32'd1);
        check_eq("pop_no_unf", {31'b0, pop_unf}, 32'd0);

        strobe_cdr(IRO);
        check_eq("unf_set", {31'b0, pop_unf}, 32'd1);
        ir_in = IRO;
        shift_bits(32, 32'h0, got);
        check_eq("unf_zero_word", got, 32'd0);
        for (int i = 0; i < 4; i++) tx_write(32'hB000_0000 + 32'(i));
        check_eq("tx_full", {31'b0, in_rdy}, 32'd0);
        in_data = 32'hBAD0_BAD0; in_valid = 1'b1;
        tick(); tick();
        check_eq("tx_full_hold", {31'b0, in_rdy}, 32'd0);
        in_valid = 1'b0;
        strobe_cdr(IRO);
        check_eq("tx_after_pop", {31'b0, in_rdy}, 32'd1);
        ir_in = IRO;
        shift_bits(32, 32'h0, got);
        check_eq("tx_first", got, 32'hB000_0000);
        read_stat(got);
        check_eq("stat_unf", got, 32'h0002_0300);
        strobe_udr(IRS, 1'b0);
        check_eq("unf_clear", {31'b0, pop_unf}, 32'd0);

        push_word(32'hC000_0000);
        push_word(32'hC000_0001);
        ir_in = IRP;
        shift_bits(32, 32'hC000_0002, got);
        strobe_udr(IRP, 1'b1);
        read_stat(got);
        check_eq("stat_simul", got, 32'h0000_0302);
        check_eq("simul_head1", out_data, 32'hC000_0001);
        ack_once();
        check_eq("simul_head2", out_data, 32'hC000_0002);
        ack_once();
        check_eq("simul_empty", {31'b0, out_rdy}, 32'd0);

        for (int i = 0; i < 4; i++) push_word(32'hD000_0000 + 32'(i));
        ir_in = IRP;
        shift_bits(32, 32'hD000_0004, got);
        strobe_udr(IRP, 1'b1);
        check_eq("full_simul_ovf", {31'b0, push_ovf}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            check_eq($sformatf("full_simul%0d", i), out_data, 32'hD000_0000 + 32'(i));
            ack_once();
        end
        check_eq("full_simul_empty", {31'b0, out_rdy}, 32'd0);

        ir_in = 3'b111; sdr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tdi = i[0];
            #1;
            check_eq($sformatf("bypass%0d", i), {31'b0, tdo}, {31'b0, i[0]});
            tick();
        end
        sdr = 1'b0;

        ir_in = IRP;
        shift_bits(10, 32'h0000_03FF, got);
        reset = 1'b1; sdr = 1'b1; tdi = 1'b1;
        tick();
        reset = 1'b0; sdr = 1'b0; tdi = 1'b0;
        #1;
        check_eq("mid_rst_rdy", {31'b0, out_rdy}, 32'd0);
        check_eq("mid_rst_data", out_data, 32'd0);
        check_eq("mid_rst_flags", {30'b0, pop_unf, push_ovf}, 32'd0);
        check_eq("mid_rst_in_rdy", {31'b0, in_rdy}, 32'd1);
        check_eq("mid_rst_tdo", {31'b0, tdo}, 32'd0);
        shift_bits(22, 32'h0025_5AC3, got);
        strobe_udr(IRP, 1'b0);
        check_eq("mid_rst_word", out_data, {22'h25_5AC3, 10'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
